// File: rtl/prog_mem.sv
// prog_mem: unified program/data memory with a front-panel byte loader.
//   clk, rst      : system clock, synchronous active-high reset
//   cpustate      : 00 STOP, 01 RUN, 10 LOAD, 11 treated as STOP
//   addr/din      : core address and write data
//   read/write    : core strobes, honoured only in RUN
//   dout          : combinational read data back to the core
//   sw_data       : operator switch byte
//   sw_load       : asynchronous commit button (level)
//   ld_ptr        : next loader write address
//   ld_done       : one-cycle pulse after each loader write
//   mem_err       : sticky out-of-range access flag
// Optional: define PROG_MEM_READBACK_EN to show the last committed byte on
// dout while in LOAD mode.
module prog_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpustate,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] din,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_load,
    output logic [ADDR_W-1:0] ld_ptr,
    output logic              ld_done,
    output logic              mem_err
);
    typedef enum logic [1:0] {L_IDLE, L_ARMED, L_WRITE, L_RELEASE} lstate_t;
    lstate_t state;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [SYNC_STAGES-1:0] sync_q;
    logic hist;
    logic run, load, in_range, sync, press, rel;
    logic [ADDR_W-1:0] idx;
    assign run      = cpustate == 2'b01;
    assign load     = cpustate == 2'b10;
    assign in_range = (addr >> ADDR_W) == 16'd0;
    assign idx      = addr[ADDR_W-1:0];
    assign sync     = sync_q[SYNC_STAGES-1];
    assign press    = sync & ~hist;
    assign rel      = ~sync & hist;
`ifdef PROG_MEM_READBACK_EN
    // Before the first commit in a LOAD session ld_ptr-1 would point at stale
    // state, so the top address is shown, matching a freshly zeroed pointer.
    logic [ADDR_W-1:0] rb_idx;
    assign rb_idx = (state == L_IDLE) ? '1 : ld_ptr - ADDR_W'(1);
    assign dout = (run && read && in_range) ? mem[idx] : (load ? mem[rb_idx] : '0);
`else
    assign dout = (run && read && in_range) ? mem[idx] : '0;
`endif
    // Array is never reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (run && write && in_range)
            mem[idx] <= din;
        else if (state == L_WRITE)
            mem[ld_ptr] <= sw_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= L_IDLE;
            ld_ptr  <= '0;
            ld_done <= 1'b0;
            mem_err <= 1'b0;
            sync_q  <= '0;
            hist    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_load};
            hist    <= sync;
            ld_done <= 1'b0;
            if (run && (read || write) && !in_range)
                mem_err <= 1'b1;
            case (state)
                L_IDLE: begin
                    if (load) begin
                        ld_ptr <= '0;
                        // A button already held on entry must not commit a byte.
                        state  <= sync ? L_RELEASE : L_ARMED;
                    end
                end
                L_ARMED:   state <= !load ? L_IDLE : (press ? L_WRITE : L_ARMED);
                L_WRITE: begin
                    ld_ptr  <= ld_ptr + ADDR_W'(1);
                    ld_done <= 1'b1;
                    state   <= load ? L_RELEASE : L_IDLE;
                end
                L_RELEASE: state <= !load ? L_IDLE : (rel ? L_ARMED : L_RELEASE);
                default:   state <= L_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: self-checking bench for prog_mem (default parameters).
module tb_prog_mem;
    logic clk = 1'b0, rst;
    logic [1:0] cpustate;
    logic [15:0] addr;
    logic [7:0] din, sw_data, dout, ld_ptr;
    logic read, write, sw_load, ld_done, mem_err;

    always #5 clk = ~clk;

    prog_mem dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .addr(addr), .din(din),
        .read(read), .write(write), .dout(dout), .sw_data(sw_data),
        .sw_load(sw_load), .ld_ptr(ld_ptr), .ld_done(ld_done), .mem_err(mem_err)
    );

    int n_cmp = 0, n_err = 0, done_cnt = 0, done_wide = 0;
    bit prev_done = 0;
    logic [7:0] ref_mem [256];
    bit known [256];
    int ref_ptr = 0;

    typedef struct {
        logic [1:0]  cs;
        bit          rd, wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_dout;
        bit          exp_err;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ld_done) done_cnt++;
        if (ld_done && prev_done) done_wide++;
        prev_done = ld_done;
    endtask

    task automatic press(input logic [7:0] b);
        sw_data = b;
        sw_load = 1'b1;
        repeat (6) tick();
        sw_load = 1'b0;
        repeat (6) tick();
        ref_mem[ref_ptr] = b;
        known[ref_ptr] = 1;
        ref_ptr = (ref_ptr + 1) % 256;
`ifdef PROG_MEM_READBACK_EN
        chk("readback", dout, b);
`endif
    endtask

    initial begin
        logic [15:0] a;
        bit rd, wr;
        logic [7:0] d;
        tbl[0]  = '{2'd1, 1, 0, 16'h0000, 8'h00, 8'hA5, 0};
        tbl[1]  = '{2'd1, 1, 0, 16'h0001, 8'h00, 8'h3C, 0};
        tbl[2]  = '{2'd1, 1, 0, 16'h0002, 8'h00, 8'hC3, 0};
        tbl[3]  = '{2'd1, 0, 1, 16'h0010, 8'h77, 8'h00, 0};
        tbl[4]  = '{2'd1, 1, 0, 16'h0010, 8'h00, 8'h77, 0};
        tbl[5]  = '{2'd1, 0, 1, 16'h0020, 8'h00, 8'h00, 0};
        tbl[6]  = '{2'd1, 1, 1, 16'h0020, 8'h5A, 8'h00, 0};
        tbl[7]  = '{2'd1, 1, 0, 16'h0020, 8'h00, 8'h5A, 0};
        tbl[8]  = '{2'd0, 1, 0, 16'h0100, 8'h00, 8'h00, 0};
        tbl[9]  = '{2'd0, 0, 1, 16'h0000, 8'h11, 8'h00, 0};
        tbl[10] = '{2'd1, 1, 0, 16'h0000, 8'h00, 8'hA5, 0};
        tbl[11] = '{2'd1, 1, 0, 16'h0100, 8'h00, 8'h00, 1};
        tbl[12] = '{2'd1, 0, 1, 16'h0100, 8'hFF, 8'h00, 1};
        tbl[13] = '{2'd1, 1, 0, 16'h0000, 8'h00, 8'hA5, 1};
        tbl[14] = '{2'd3, 1, 0, 16'h0010, 8'h00, 8'h00, 1};
        for (int i = 0; i < 256; i++) known[i] = 0;

        rst = 1; cpustate = 2'b10; read = 0; write = 0; addr = 0; din = 0;
        sw_data = 0; sw_load = 0;
        tick();
        chk("rst_ld_ptr", ld_ptr, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_mem_err", mem_err, 0);
`ifndef PROG_MEM_READBACK_EN
        chk("rst_dout", dout, 0);
`endif
        rst = 0;
        tick(); tick();
        done_cnt = 0; done_wide = 0;
        press(8'hA5);
        press(8'h3C);
        chk("two_pulses", done_cnt, 2);
        chk("pulse_width", done_wide, 0);
        chk("ld_ptr_2", ld_ptr, 2);

        sw_data = 8'hC3;
        sw_load = 1;
        repeat (20) tick();
        sw_load = 0;
        repeat (6) tick();
        ref_mem[2] = 8'hC3; known[2] = 1; ref_ptr = 3;
        chk("hold_one_pulse", done_cnt, 3);
        chk("hold_ptr", ld_ptr, 3);

        for (int i = 0; i < 15; i++) begin
            cpustate = tbl[i].cs; read = tbl[i].rd; write = tbl[i].wr;
            addr = tbl[i].a; din = tbl[i].d;
            #2;
            chk($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
            tick();
            chk($sformatf("vec%0d_err", i), mem_err, tbl[i].exp_err);
            if (tbl[i].cs == 2'd1 && tbl[i].wr && tbl[i].a < 16'd256) begin
                ref_mem[tbl[i].a[7:0]] = tbl[i].d;
                known[tbl[i].a[7:0]] = 1;
            end
        end
        read = 0; write = 0;
        chk("ptr_kept", ld_ptr, 3);

        cpustate = 2'b01;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(256, 65535))
                                             : 16'($urandom_range(0, 255));
            rd = 1'($urandom); wr = 1'($urandom); d = 8'($urandom);
            addr = a; read = rd; write = wr; din = d;
            #2;
            if (!(rd && a < 16'd256 && !known[a[7:0]]))
                chk("rand_dout", dout, (rd && a < 16'd256) ? ref_mem[a[7:0]] : 8'h00);
            tick();
            chk("rand_err", mem_err, 1);
            if (wr && a < 16'd256) begin
                ref_mem[a[7:0]] = d;
                known[a[7:0]] = 1;
            end
        end
        read = 0; write = 0;

        cpustate = 2'b10;
        tick(); tick();
        chk("load_entry_ptr", ld_ptr, 0);
        ref_ptr = 0;
        done_cnt = 0;
        for (int i = 0; i < 257; i++) press(8'($urandom));
        chk("wrap_ptr", ld_ptr, 1);
        chk("wrap_pulses", done_cnt, 257);
        chk("wrap_no_err_change", mem_err, 1);
        cpustate = 2'b01;
        tick();
        chk("ptr_kept_run", ld_ptr, 1);
        for (int i = 0; i < 256; i++) begin
            addr = 16'(i); read = 1;
            #2;
            chk($sformatf("wrap_rd%0d", i), dout, ref_mem[i]);
            tick();
        end
        read = 0;

        cpustate = 2'b10;
        tick(); tick();
        ref_ptr = 0;
        press(8'h99);
        sw_load = 1;
        tick();
        rst = 1;
        tick();
        rst = 0; sw_load = 0;
        chk("midrst_ptr", ld_ptr, 0);
        chk("midrst_err", mem_err, 0);
        chk("midrst_done", ld_done, 0);
        repeat (8) tick();
        chk("midrst_no_write", ld_ptr, 0);
        cpustate = 2'b01;
        for (int i = 0; i < 2; i++) begin
            addr = 16'(i); read = 1;
            #2;
            chk($sformatf("midrst_rd%0d", i), dout, ref_mem[i]);
            tick();
        end
        read = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
